// File: rtl/jtkunio_gfxrom_pkg.sv
// Shared types and constants for the graphics ROM responder: FSM states,
// channel ids, default SDRAM region bases and the word-address helper.
package jtkunio_gfxrom_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_e;
  typedef enum logic [1:0] {CH_CHAR = 2'd0, CH_SCR = 2'd1, CH_OBJ = 2'd2} ch_e;

  localparam int NUM_CH = 3;
  localparam int AW     = 18;  // widest requester address (obj)

  localparam logic [21:0] CHAR_OFFSET_DEF = 22'h00000;
  localparam logic [21:0] SCR_OFFSET_DEF  = 22'h08000;
  localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h48000;

  // 32-bit word address -> 16-bit SDRAM word address, wrapping at 2^22
  function automatic logic [21:0] rom_addr(input logic [21:0] off, input logic [AW-1:0] a);
    return off + {3'b000, a, 1'b0};
  endfunction

endpackage

// File: rtl/jtkunio_gfxrom_if.sv
// Request/ok bus of the three ROM channels plus the 16-bit SDRAM read port.
interface jtkunio_gfxrom_if;
  logic [13:0] char_addr;
  logic [31:0] char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] sdram_din;

  modport slave (
    input  char_addr, scr_addr, obj_cs, obj_addr, sdram_ack, sdram_rdy, sdram_din,
    output char_data, char_ok, scr_data, scr_ok, obj_data, obj_ok, sdram_addr, sdram_req
  );

  modport master (
    output char_addr, scr_addr, obj_cs, obj_addr, sdram_ack, sdram_rdy, sdram_din,
    input  char_data, char_ok, scr_data, scr_ok, obj_data, obj_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtkunio_gfxrom_slot.sv
// One channel's single-entry cache: latched address/data, valid flag and
// the combinational hit compare that drives ok.
module jtkunio_gfxrom_slot
  import jtkunio_gfxrom_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i,
  output logic [31:0]   data_o,
  output logic          ok_o,
  output logic          pend_o
);

  logic [AW-1:0] lat_q, lat_d;
  logic          vld_q, vld_d;
  logic [31:0]   data_q, data_d;

  always_comb begin
    lat_d  = lat_q;
    vld_d  = vld_q;
    data_d = data_q;
    if (ld_i) begin
      lat_d  = ld_addr_i;
      vld_d  = 1'b1;
      data_d = ld_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      lat_q  <= lat_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign ok_o   = cs_i & vld_q & (addr_i == lat_q);
  assign pend_o = cs_i & ~ok_o;

endmodule

// File: rtl/jtkunio_gfxrom.sv
// Serves the char/scroll/object 32-bit ROM ports from one 16-bit SDRAM read
// port: fixed-priority pick in IDLE, request/ack, then two data beats.
module jtkunio_gfxrom
  import jtkunio_gfxrom_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = CHAR_OFFSET_DEF,
  parameter logic [21:0] SCR_OFFSET  = SCR_OFFSET_DEF,
  parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  jtkunio_gfxrom_if.slave bus
);

  logic [NUM_CH-1:0][AW-1:0] req_addr;
  logic [NUM_CH-1:0][21:0]   offs;
  logic [NUM_CH-1:0][31:0]   data;
  logic [NUM_CH-1:0]         cs, ld, ok, pend;

  state_e        state_q, state_d;
  ch_e           ch_q, ch_d, sel_ch;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   lo_q, lo_d;
  logic [21:0]   saddr_q, saddr_d;
  logic          req_q, req_d;

  assign req_addr[CH_CHAR] = {4'b0, bus.char_addr};
  assign req_addr[CH_SCR]  = {1'b0, bus.scr_addr};
  assign req_addr[CH_OBJ]  = bus.obj_addr;
  assign offs[CH_CHAR]     = CHAR_OFFSET;
  assign offs[CH_SCR]      = SCR_OFFSET;
  assign offs[CH_OBJ]      = OBJ_OFFSET;
  assign cs                = {bus.obj_cs, 1'b1, 1'b1};

  // char > scr > obj
  always_comb begin
    sel_ch = CH_OBJ;
    if (pend[CH_SCR])  sel_ch = CH_SCR;
    if (pend[CH_CHAR]) sel_ch = CH_CHAR;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    saddr_d = saddr_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (|pend) begin
        ch_d    = sel_ch;
        addr_d  = req_addr[sel_ch];
        saddr_d = rom_addr(offs[sel_ch], req_addr[sel_ch]);
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.sdram_ack) begin
        req_d = 1'b0;
        // a beat arriving alongside the ack is the first data beat
        if (bus.sdram_rdy) begin
          lo_d    = bus.sdram_din;
          state_d = BEAT1;
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT0: if (bus.sdram_rdy) begin
        lo_d    = bus.sdram_din;
        state_d = BEAT1;
      end
      BEAT1: if (bus.sdram_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= CH_CHAR;
      addr_q  <= '0;
      lo_q    <= '0;
      saddr_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      saddr_q <= saddr_d;
      req_q   <= req_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign ld[i] = (state_q == BEAT1) & bus.sdram_rdy & (ch_q == ch_e'(i));

    jtkunio_gfxrom_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_i      (cs[i]),
      .addr_i    (req_addr[i]),
      .ld_i      (ld[i]),
      .ld_addr_i (addr_q),
      .ld_data_i ({bus.sdram_din, lo_q}),
      .data_o    (data[i]),
      .ok_o      (ok[i]),
      .pend_o    (pend[i])
    );
  end

  assign bus.char_data  = data[CH_CHAR];
  assign bus.char_ok    = ok[CH_CHAR];
  assign bus.scr_data   = data[CH_SCR];
  assign bus.scr_ok     = ok[CH_SCR];
  assign bus.obj_data   = data[CH_OBJ];
  assign bus.obj_ok     = ok[CH_OBJ];
  assign bus.sdram_addr = saddr_q;
  assign bus.sdram_req  = req_q;

endmodule

// File: tb/tb_jtkunio_gfxrom.sv
// Directed bench: a task-driven SDRAM responder feeds hand-picked beats and
// every result is compared against constants chosen here.
module tb_jtkunio_gfxrom;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  jtkunio_gfxrom_if bus ();

  jtkunio_gfxrom #(.OBJ_OFFSET(22'h3C0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  // mode 0: normal fetch; 1: move char_addr to 8 in BEAT0; 2: reset in BEAT1
  task automatic serve(input string tag, input logic [21:0] exp_addr,
                       input logic [15:0] lo, input logic [15:0] hi, input int mode);
    int n = 0;
    while (!bus.sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(bus.sdram_req), 32'd1);
    chk({tag, "_addr"}, 32'(bus.sdram_addr), 32'(exp_addr));
    @(negedge clk);
    @(negedge clk);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    chk({tag, "_reqdrop"}, 32'(bus.sdram_req), 32'd0);
    if (mode == 1) bus.char_addr = 14'h0008;
    bus.sdram_rdy = 1'b1;
    bus.sdram_din = lo;
    @(negedge clk);
    bus.sdram_rdy = 1'b0;
    bus.sdram_din = 16'h0;
    chk({tag, "_objok_mid"}, 32'(bus.obj_ok), 32'd0);
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_oks"}, 32'({bus.char_ok, bus.scr_ok, bus.obj_ok}), 32'd0);
      chk({tag, "_rst_req"}, 32'(bus.sdram_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.sdram_rdy = 1'b1;
      bus.sdram_din = hi;
      @(negedge clk);
      bus.sdram_rdy = 1'b0;
      return;
    end
    @(negedge clk);
    bus.sdram_rdy = 1'b1;
    bus.sdram_din = hi;
    @(negedge clk);
    bus.sdram_rdy = 1'b0;
    bus.sdram_din = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.char_addr = 14'h0005;
    bus.scr_addr  = 17'h0;
    bus.obj_cs    = 1'b0;
    bus.obj_addr  = 18'h0;
    bus.sdram_ack = 1'b0;
    bus.sdram_rdy = 1'b0;
    bus.sdram_din = 16'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_char_data", bus.char_data, 32'h0);
    chk("rst_oks", 32'({bus.char_ok, bus.scr_ok, bus.obj_ok}), 32'd0);
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    rst_n = 1'b1;

    // first char fetch, then the scroll slot (never valid after reset)
    serve("t1_char", 22'h0000A, 16'h1234, 16'hABCD, 0);
    chk("t1_char_data", bus.char_data, 32'hABCD1234);
    chk("t1_char_ok", 32'(bus.char_ok), 32'd1);
    chk("t1_scr_ok", 32'(bus.scr_ok), 32'd0);
    chk("t1_obj_ok", 32'(bus.obj_ok), 32'd0);
    serve("t1_scr", 22'h08000, 16'h1111, 16'h2222, 0);
    chk("t1_scr_data", bus.scr_data, 32'h22221111);

    // simultaneous char and scroll change: char wins
    bus.char_addr = 14'h0006;
    bus.scr_addr  = 17'h00010;
    serve("t2_char", 22'h0000C, 16'h0606, 16'h6060, 0);
    serve("t2_scr", 22'h08020, 16'h5A5A, 16'hA5A5, 0);
    chk("t2_oks", 32'({bus.char_ok, bus.scr_ok}), 32'd3);
    chk("t2_char_data", bus.char_data, 32'h60600606);
    chk("t2_scr_data", bus.scr_data, 32'hA5A55A5A);

    // object address wraps past 2^22
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h3FFFF;
    serve("t3_obj", 22'h03FFFE, 16'hBEEF, 16'hDEAD, 0);
    chk("t3_obj_ok", 32'(bus.obj_ok), 32'd1);
    chk("t3_obj_data", bus.obj_data, 32'hDEADBEEF);
    bus.obj_cs = 1'b0;
    #1;
    chk("t3_obj_ok_cs0", 32'(bus.obj_ok), 32'd0);

    // address moves during BEAT0: old fetch stored, new one follows at once
    bus.char_addr = 14'h0007;
    serve("t4_char7", 22'h0000E, 16'h7777, 16'h0007, 1);
    chk("t4_char_ok", 32'(bus.char_ok), 32'd0);
    chk("t4_char_data", bus.char_data, 32'h00077777);
    chk("t4_idle_req", 32'(bus.sdram_req), 32'd0);
    @(negedge clk);
    chk("t4_next_req", 32'(bus.sdram_req), 32'd1);
    serve("t4_char8", 22'h00010, 16'h8888, 16'h0008, 0);
    chk("t4_char_ok2", 32'(bus.char_ok), 32'd1);
    chk("t4_char_data2", bus.char_data, 32'h00088888);

    // reset in BEAT1, stray beat afterwards, then refetch
    bus.char_addr = 14'h0009;
    serve("t5_abort", 22'h00012, 16'hFFFF, 16'hEEEE, 2);
    chk("t5_char_data_rst", bus.char_data, 32'h0);
    serve("t5_char", 22'h00012, 16'h9999, 16'h0009, 0);
    chk("t5_char_ok", 32'(bus.char_ok), 32'd1);
    chk("t5_char_data", bus.char_data, 32'h00099999);
    serve("t5_scr", 22'h08020, 16'h1010, 16'h0101, 0);
    chk("t5_scr_data", bus.scr_data, 32'h01011010);

    // brief excursion away from the latched address: no fetch
    bus.char_addr = 14'h000A;
    #1;
    chk("t6_ok_drop", 32'(bus.char_ok), 32'd0);
    bus.char_addr = 14'h0009;
    #1;
    chk("t6_ok_back", 32'(bus.char_ok), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_no_req", 32'(bus.sdram_req), 32'd0);
    bus.char_addr = 14'h000A;
    serve("t6_charA", 22'h00014, 16'hAAAA, 16'h000A, 0);
    chk("t6_char_ok", 32'(bus.char_ok), 32'd1);
    chk("t6_char_data", bus.char_data, 32'h000AAAAA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
